intc_req_ctrl: RTL

//  Per-CPU interrupt request sequencer between intc_sel and the CPU interrupt ports.

---
 rtl/intc_req_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/intc_req_ctrl.sv
// intc_req_ctrl: per-CPU interrupt request sequencer.
// Sits between intc_sel and the CPU interrupt ports. It latches the selected
// level/vector, holds them stable until the CPU acks, returns a one-cycle
// intack pulse to the selection logic, then enforces a hold-off window.
// One FSM instance per CPU. The instances share no state.
//
// Optional feature: define INTC_REQ_TIMEOUT_EN to withdraw a request that
// has not been acked within TMO_CYC cycles. Without it, tmo_o is tied to 0
// and REQ waits indefinitely for an ack.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no request pending; accepts a valid request from intc_sel
// REQ     | request presented to CPU; waits for ack, preempt or withdraw
// HOLD    | post-ack/timeout hold-off; intc_sel request ignored

module intc_req_ctrl #(
    parameter int unsigned CPU_NUM  = 1,
    parameter int unsigned HOLD_CYC = 2,
    parameter int unsigned TMO_CYC  = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CPU_NUM-1:0]     sl_req_i,
    input  logic [CPU_NUM*5-1:0]   sl_level_i,
    input  logic [CPU_NUM*8-1:0]   sl_vec_i,
    input  logic [CPU_NUM-1:0]     cpu_int_ack_i,
    output logic [CPU_NUM-1:0]     cpu_int_req_o,
    output logic [CPU_NUM*5-1:0]   cpu_int_level_o,
    output logic [CPU_NUM*8-1:0]   cpu_int_vec_o,
    output logic [CPU_NUM-1:0]     cp_intack_all_o,
    output logic [CPU_NUM-1:0]     spur_ack_o,
    output logic [CPU_NUM-1:0]     tmo_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // The hold-off counter is 4 bits wide, so HOLD_CYC is taken modulo 16.
    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYC);

    for (genvar g = 0; g < CPU_NUM; g++) begin : g_cpu
        state_e      state_q;
        logic [3:0]  hold_cnt_q;
        logic        req_q;
        logic [4:0]  level_q;
        logic [7:0]  vec_q;
        logic        intack_q;
        logic        spur_q;

        logic [4:0]  lvl_in;
        logic [7:0]  vec_in;
        logic        ack_in;
        logic        valid_in;
        logic        preempt;

        assign lvl_in   = sl_level_i[g*5 +: 5];
        assign vec_in   = sl_vec_i[g*8 +: 8];
        assign ack_in   = cpu_int_ack_i[g];
        // Level 0 means "nothing selected", so a request only counts with a
        // nonzero level.
        assign valid_in = sl_req_i[g] && (lvl_in != 5'd0);
        assign preempt  = valid_in && (lvl_in > level_q);

`ifdef INTC_REQ_TIMEOUT_EN
        logic [7:0]  tmo_cnt_q;
        logic        tmo_q;
        logic        tmo_hit;

        // Counter starts at 0 on the first REQ cycle, so expiry on the
        // TMO_CYC-1 count gives exactly TMO_CYC cycles of req=1.
        assign tmo_hit = (tmo_cnt_q == 8'(TMO_CYC - 1));
`endif

        // Per-CPU request sequencer FSM. All outputs are registered here.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q    <= ST_IDLE;
                hold_cnt_q <= 4'd0;
                req_q      <= 1'b0;
                level_q    <= 5'd0;
                vec_q      <= 8'd0;
                intack_q   <= 1'b0;
                spur_q     <= 1'b0;
`ifdef INTC_REQ_TIMEOUT_EN
                tmo_cnt_q  <= 8'd0;
                tmo_q      <= 1'b0;
`endif
            end else begin
                intack_q <= 1'b0;
                spur_q   <= 1'b0;
`ifdef INTC_REQ_TIMEOUT_EN
                tmo_q    <= 1'b0;
`endif
                case (state_q)
                    ST_IDLE: begin
                        if (ack_in) begin
                            spur_q <= 1'b1;
                        end
                        if (valid_in) begin
                            level_q <= lvl_in;
                            vec_q   <= vec_in;
                            req_q   <= 1'b1;
                            state_q <= ST_REQ;
`ifdef INTC_REQ_TIMEOUT_EN
                            tmo_cnt_q <= 8'd0;
`endif
                        end
                    end

                    ST_REQ: begin
                        // Ack has priority over everything else, so the
                        // values the CPU acked are the ones left on the port.
                        if (ack_in) begin
                            req_q      <= 1'b0;
                            intack_q   <= 1'b1;
                            hold_cnt_q <= HOLD_INIT;
                            state_q    <= ST_HOLD;
                        end else if (!valid_in) begin
                            req_q   <= 1'b0;
                            state_q <= ST_IDLE;
`ifdef INTC_REQ_TIMEOUT_EN
                        end else if (tmo_hit) begin
                            req_q      <= 1'b0;
                            tmo_q      <= 1'b1;
                            hold_cnt_q <= HOLD_INIT;
                            state_q    <= ST_HOLD;
`endif
                        end else if (preempt) begin
                            level_q <= lvl_in;
                            vec_q   <= vec_in;
`ifdef INTC_REQ_TIMEOUT_EN
                            tmo_cnt_q <= 8'd0;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 8'd1;
`endif
                        end
                    end

                    ST_HOLD: begin
                        if (ack_in) begin
                            spur_q <= 1'b1;
                        end
                        if (hold_cnt_q == 4'd0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - 4'd1;
                        end
                    end

                    default: begin
                        req_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end

        assign cpu_int_req_o[g]          = req_q;
        assign cpu_int_level_o[g*5 +: 5] = level_q;
        assign cpu_int_vec_o[g*8 +: 8]   = vec_q;
        assign cp_intack_all_o[g]        = intack_q;
        assign spur_ack_o[g]             = spur_q;
`ifdef INTC_REQ_TIMEOUT_EN
        assign tmo_o[g]                  = tmo_q;
`endif
    end

`ifndef INTC_REQ_TIMEOUT_EN
    assign tmo_o = '0;
`endif

endmodule
